bsg_wormhole_packet_arbiter: RTL and testbench

BSG_WORMHOLE_PACKET_ARBITER -- requirements
Module: bsg_wormhole_packet_arbiter

---
 rtl/bsg_wormhole_packet_arbiter.sv | 141 ++++++++++++++
 tb/tb_bsg_wormhole_packet_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_packet_arbiter.sv
// Round-robin wormhole packet arbiter: holds one input for a whole packet (header + len body flits).
// Optional per-input completed-packet counters: define BSG_WORMHOLE_PACKET_ARB_PKT_CNT_EN.
module bsg_wormhole_packet_arbiter #(
    parameter int unsigned num_in_p     = 4,
    parameter int unsigned flit_width_p = 32,
    parameter int unsigned cord_width_p = 8,
    parameter int unsigned len_width_p  = 4
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic [num_in_p-1:0]                     links_v_i,
    input  logic [num_in_p-1:0][flit_width_p-1:0]   links_data_i,
    output logic [num_in_p-1:0]                     links_yumi_o,
    output logic                                    out_v_o,
    output logic [flit_width_p-1:0]                 out_data_o,
    input  logic                                    out_ready_and_i,
    output logic [num_in_p-1:0]                     grant_o,
    output logic                                    busy_o,
    output logic [num_in_p-1:0][15:0]               pkt_count_o
);
    localparam int unsigned idx_w = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;
    logic [idx_w-1:0]       rr_q, rr_d;
    logic [idx_w-1:0]       lock_q, lock_d;
    logic [idx_w-1:0]       sel_idx;
    logic [idx_w-1:0]       cur_idx;
    logic [idx_w-1:0]       next_ptr;
    logic                   sel_found;
    logic [len_width_p-1:0] hdr_len;
    logic                   xfer;
    int unsigned            scan_j;

    // First valid input at or after rr_q, wrapping upward
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_j    = 0;
        for (int unsigned k = 0; k < num_in_p; k++) begin
            scan_j = 32'(rr_q) + k;
            if (scan_j >= num_in_p) scan_j = scan_j - num_in_p;
            if (!sel_found && links_v_i[idx_w'(scan_j)]) begin
                sel_found = 1'b1;
                sel_idx   = idx_w'(scan_j);
            end
        end
    end

    assign cur_idx  = (state_q == LOCKED) ? lock_q : sel_idx;
    assign next_ptr = (cur_idx == idx_w'(num_in_p - 1)) ? '0 : cur_idx + idx_w'(1);
    assign hdr_len  = links_data_i[cur_idx][cord_width_p +: len_width_p];

    // Outputs are forced low while reset is held, even though IDLE selection is combinational
    always_comb begin
        grant_o = '0;
        out_v_o = 1'b0;
        if (reset_n_i) begin
            if (state_q == LOCKED) begin
                grant_o[cur_idx] = 1'b1;
                out_v_o          = links_v_i[cur_idx];
            end else if (sel_found) begin
                grant_o[cur_idx] = 1'b1;
                out_v_o          = 1'b1;
            end
        end
    end

    assign out_data_o   = links_data_i[cur_idx];
    assign xfer         = out_v_o & out_ready_and_i;
    assign links_yumi_o = grant_o & {num_in_p{xfer}};
    assign busy_o       = (state_q == LOCKED);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (hdr_len == '0) begin
                        rr_d = next_ptr;
                    end else begin
                        state_d = LOCKED;
                        cnt_d   = hdr_len;
                        lock_d  = cur_idx;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = IDLE;
                        rr_d    = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
        end
    end

`ifdef BSG_WORMHOLE_PACKET_ARB_PKT_CNT_EN
    logic                     pkt_done;
    logic [num_in_p-1:0][15:0] pkt_cnt_q;

    // A packet completes on a zero-length header or on the tail flit
    assign pkt_done = xfer & (((state_q == IDLE) && (hdr_len == '0)) ||
                              ((state_q == LOCKED) && (cnt_q == len_width_p'(1))));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pkt_cnt_q <= '0;
        end else if (pkt_done) begin
            pkt_cnt_q[cur_idx] <= pkt_cnt_q[cur_idx] + 16'd1;
        end
    end

    assign pkt_count_o = pkt_cnt_q;
`else
    assign pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_wormhole_packet_arbiter.sv
// Bench for bsg_wormhole_packet_arbiter: upstream packet FIFOs plus a packet-level arbitration model.
`timescale 1ns/1ps
module tb_bsg_wormhole_packet_arbiter;
    localparam int N     = 4;
    localparam int FW    = 32;
    localparam int CW    = 8;
    localparam int LW    = 4;
    localparam int DEPTH = 256;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [N-1:0]            links_v;
    logic [N-1:0][FW-1:0]    links_data;
    logic [N-1:0]            links_yumi;
    logic                    out_v;
    logic [FW-1:0]           out_data;
    logic                    out_ready;
    logic [N-1:0]            grant;
    logic                    busy;
    logic [N-1:0][15:0]      pkt_count;

    bsg_wormhole_packet_arbiter #(
        .num_in_p(N), .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .links_v_i(links_v), .links_data_i(links_data), .links_yumi_o(links_yumi),
        .out_v_o(out_v), .out_data_o(out_data), .out_ready_and_i(out_ready),
        .grant_o(grant), .busy_o(busy), .pkt_count_o(pkt_count)
    );

    always #5 clk = ~clk;

    // Upstream FIFOs holding whole packets per input
    logic [FW-1:0] fifo_d [N][DEPTH];
    int            head [N];
    int            tail [N];
    bit            en [N];

    // Packet-level model: owner of the output (-1 = free), flits left, fairness pointer
    int m_owner, m_left, m_rr;
    int m_pcnt [N];

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0]  obs_grant, obs_yumi;
    logic          obs_v, obs_busy;
    logic [FW-1:0] obs_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int i, input int len);
        logic [FW-1:0] w;
        w = $urandom;
        w[CW +: LW] = LW'(len);
        fifo_d[i][tail[i] % DEPTH] = w;
        tail[i]++;
        for (int b = 0; b < len; b++) begin
            w = $urandom;
            fifo_d[i][tail[i] % DEPTH] = w;
            tail[i]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            links_v[i]    = en[i] && (head[i] != tail[i]);
            links_data[i] = (head[i] != tail[i]) ? fifo_d[i][head[i] % DEPTH] : '0;
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_rr    = 0;
        for (int i = 0; i < N; i++) begin
            m_pcnt[i] = 0;
            head[i]   = 0;
            tail[i]   = 0;
        end
    endtask

    function automatic int exp_idx();
        if (m_owner >= 0) return m_owner;
        for (int k = 0; k < N; k++)
            if (links_v[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic logic [15:0] exp_pcnt(input int i);
`ifdef BSG_WORMHOLE_PACKET_ARB_PKT_CNT_EN
        return 16'(m_pcnt[i] % 65536);
`else
        return 16'd0;
`endif
    endfunction

    // One cycle: drive, compare at negedge, then advance model past the posedge
    task automatic step();
        int           e;
        int           len;
        logic [N-1:0] eg;
        logic         ev;
        logic         xf;
        drive();
        @(negedge clk);
        obs_grant = grant;
        obs_v     = out_v;
        obs_data  = out_data;
        obs_yumi  = links_yumi;
        obs_busy  = busy;
        e  = exp_idx();
        eg = '0;
        if (e >= 0) eg[e] = 1'b1;
        ev = (m_owner >= 0) ? links_v[m_owner] : (|links_v);
        xf = ev && out_ready;
        chk("grant", 64'(grant), 64'(eg));
        chk("out_v", 64'(out_v), 64'(ev));
        chk("yumi", 64'(links_yumi), xf ? 64'(eg) : 64'd0);
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        if (ev) chk("out_data", 64'(out_data), 64'(fifo_d[e][head[e] % DEPTH]));
        for (int i = 0; i < N; i++) chk("pkt_count", 64'(pkt_count[i]), 64'(exp_pcnt(i)));
        @(posedge clk);
        #1;
        if (xf) begin
            if (m_owner < 0) begin
                len = int'(fifo_d[e][head[e] % DEPTH][CW +: LW]);
                if (len == 0) begin
                    m_rr = (e + 1) % N;
                    m_pcnt[e]++;
                end else begin
                    m_owner = e;
                    m_left  = len;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_owner = -1;
                    m_rr    = (e + 1) % N;
                    m_pcnt[e]++;
                end
            end
            head[e]++;
        end
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        model_reset();
        links_v   = '1;
        for (int i = 0; i < N; i++) links_data[i] = $urandom;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out_v", 64'(out_v), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_yumi", 64'(links_yumi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) en[i] = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        links_v    = '0;
        links_data = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        model_reset();

        // Two zero-length packets on inputs 0 and 2, then pointer lands on 3
        apply_reset();
        push_pkt(0, 0);
        push_pkt(2, 0);
        step(); chk("rr_c0_grant", 64'(obs_grant), 64'h1);
        step(); chk("rr_c1_grant", 64'(obs_grant), 64'h4);
        push_pkt(0, 0);
        push_pkt(3, 0);
        step(); chk("rr_ptr3_grant", 64'(obs_grant), 64'h8);
        step(); chk("rr_wrap_grant", 64'(obs_grant), 64'h1);
        step(); chk("rr_idle_v", 64'(obs_v), 64'd0);

        // Input 1 holds the output for header + 3 bodies, input 0 follows with no bubble
        apply_reset();
        push_pkt(0, 0);
        push_pkt(1, 3);
        push_pkt(0, 0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("lock_grant", 64'(obs_grant), (c == 0 || c == 5) ? 64'h1 : 64'h2);
            chk("lock_yumi", 64'(obs_yumi), (c == 0 || c == 5) ? 64'h1 : 64'h2);
            chk("lock_busy", 64'(obs_busy), (c >= 2 && c <= 4) ? 64'd1 : 64'd0);
        end

        // Locked input 3 stalls for 5 cycles while others wait
        apply_reset();
        push_pkt(3, 3);
        step(); chk("stall_hdr", 64'(obs_grant), 64'h8);
        step(); chk("stall_body1", 64'(obs_yumi), 64'h8);
        en[3] = 1'b0;
        push_pkt(0, 0);
        push_pkt(1, 0);
        push_pkt(2, 0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_v", 64'(obs_v), 64'd0);
            chk("stall_yumi", 64'(obs_yumi), 64'd0);
            chk("stall_grant", 64'(obs_grant), 64'h8);
        end
        en[3] = 1'b1;
        step(); chk("resume_body2", 64'(obs_yumi), 64'h8);
        step(); chk("resume_tail", 64'(obs_yumi), 64'h8);
        step(); chk("after_tail", 64'(obs_grant), 64'h1);

        // Backpressure mid-packet
        apply_reset();
        push_pkt(2, 2);
        step(); chk("bp_hdr", 64'(obs_yumi), 64'h4);
        step(); chk("bp_body1", 64'(obs_yumi), 64'h4);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_yumi", 64'(obs_yumi), 64'd0);
            chk("bp_busy", 64'(obs_busy), 64'd1);
            chk("bp_data", 64'(obs_data), 64'(fifo_d[2][2]));
        end
        out_ready = 1'b1;
        step(); chk("bp_tail", 64'(obs_yumi), 64'h4);
        step(); chk("bp_done_busy", 64'(obs_busy), 64'd0);

        // Asynchronous reset mid-packet, then restart from input 0
        apply_reset();
        push_pkt(1, 3);
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_v", 64'(out_v), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_yumi", 64'(links_yumi), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_pkt(1, 0);
        push_pkt(0, 1);
        step(); chk("arst_first", 64'(obs_grant), 64'h1);
        step(); chk("arst_hdr_lock", 64'(obs_busy), 64'd1);
        step(); chk("arst_next", 64'(obs_grant), 64'h2);

        // Randomized traffic, including maximum-length packets
        apply_reset();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ((tail[i] - head[i]) < 60 && $urandom_range(0, 3) == 0)
                    push_pkt(i, ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5)));
                en[i] = ($urandom_range(0, 9) != 0);
            end
            out_ready = ($urandom_range(0, 4) != 0);
            step();
        end

`ifdef BSG_WORMHOLE_PACKET_ARB_PKT_CNT_EN
        apply_reset();
        out_ready = 1'b1;
        for (int p = 0; p < 70000; p++) begin
            push_pkt(1, 0);
            step();
        end
        @(negedge clk);
        chk("pkt_count_wrap", 64'(pkt_count[1]), 64'd4464);
`else
        @(negedge clk);
        chk("pkt_count_off", 64'(pkt_count), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
